apb_multi_slave_memory: RTL and testbench

- APB4 completer modelling NO_OF_SLAVES independent word-addressed memories behind one shared APB bus.
- Selects the target slave from one-hot pselx and applies byte strobes on writes.
- Inserts a per-slave programmable number of wait states.
- Flags pslverr on decode, alignment, range or strobe violations.
- Sits on the DUT side of the APB AVIP as the reusable slave-side memory for multi-slave environments.

---
 rtl/apb_global_pkg.sv | 10 +
 rtl/apb_slave_mem_bank.sv | 19 +
 rtl/apb_multi_slave_memory.sv | 127 ++++++++++++
 tb/tb_apb_multi_slave_memory.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/apb_global_pkg.sv
// apb_global_pkg: shared APB defaults, FSM/response/transfer types and internal error-cause codes
package apb_global_pkg;
    localparam int NO_OF_SLAVES  = 4;
    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_fsm_state_e;
    typedef enum logic {NO_ERROR, ERROR} slave_error_e;
    typedef enum logic {READ, WRITE} tx_type_e;
    typedef enum logic [2:0] {NONE, MULTI_SEL, UNALIGNED, OUT_OF_RANGE, READ_STRB, PROT} apb_err_cause_e;
endpackage

// File: rtl/apb_slave_mem_bank.sv
// apb_slave_mem_bank: word memory with byte-enable write and combinational read, no reset
module apb_slave_mem_bank #(
    parameter int DEPTH = 256,
    parameter int DW    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DW-1:0]            i_wdata,
    input  logic [DW/8-1:0]          i_strb,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DW-1:0]            o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    always_ff @(posedge i_clk)
        for (int b = 0; b < DW/8; b++)
            if (i_we && i_strb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/apb_multi_slave_memory.sv
// apb_multi_slave_memory: APB4 multi-slave memory completer with wait states; APB_PPROT_CHECK_EN adds a slave-0 secure-access check
module apb_multi_slave_memory
    import apb_global_pkg::*;
#(
    parameter int NO_OF_SLAVES    = apb_global_pkg::NO_OF_SLAVES,
    parameter int ADDRESS_WIDTH   = apb_global_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH      = apb_global_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH_WORDS = 256,
    parameter int SLAVE_SPAN_LOG2 = 12,
    parameter int WAIT_WIDTH      = 4
) (
    input  logic                               pclk,
    input  logic                               preset_n,
    input  logic [NO_OF_SLAVES-1:0]            pselx,
    input  logic                               penable,
    input  logic                               pwrite,
    input  logic [ADDRESS_WIDTH-1:0]           paddr,
    input  logic [DATA_WIDTH-1:0]              pwdata,
    input  logic [DATA_WIDTH/8-1:0]            pstrb,
    input  logic [2:0]                         pprot,
    input  logic [NO_OF_SLAVES*WAIT_WIDTH-1:0] cfg_wait_states,
    output logic [DATA_WIDTH-1:0]              prdata,
    output logic                               pready,
    output logic                               pslverr
);
    localparam int BW  = DATA_WIDTH/8;
    localparam int LSB = BW > 1 ? $clog2(BW) : 0;
    localparam int XW  = SLAVE_SPAN_LOG2 - LSB;
    localparam int AW  = $clog2(MEM_DEPTH_WORDS);
    localparam int SW  = NO_OF_SLAVES > 1 ? $clog2(NO_OF_SLAVES) : 1;

    logic [XW-1:0]           w_word;
    logic [AW-1:0]           w_raddr;
    logic [SW-1:0]           w_sel;
    logic [DATA_WIDTH-1:0]   w_rd [NO_OF_SLAVES];
    logic [NO_OF_SLAVES-1:0] w_we;
    logic                    w_prot_err;
    logic                    w_done;
    apb_err_cause_e          w_cause;
    slave_error_e            w_resp;

    apb_fsm_state_e          r_state;
    logic [WAIT_WIDTH-1:0]   r_cnt;
    tx_type_e                r_tx;
    logic [AW-1:0]           r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [BW-1:0]           r_strb;
    logic [2:0]              r_prot;
    logic [SW-1:0]           r_idx;
    apb_err_cause_e          r_cause;
    logic [DATA_WIDTH-1:0]   r_rdata;

    assign w_word  = paddr[SLAVE_SPAN_LOG2-1:LSB];
    assign w_raddr = AW'(w_word);

    // lowest set select bit wins; multi-select is flagged as an error anyway
    always_comb begin
        w_sel = '0;
        for (int k = NO_OF_SLAVES-1; k >= 0; k--)
            if (pselx[k]) w_sel = SW'(k);
    end

`ifdef APB_PPROT_CHECK_EN
    assign w_prot_err = w_sel == '0 && pprot[1];
`else
    assign w_prot_err = 1'b0;
`endif

    always_comb
        w_cause = (pselx & (pselx - NO_OF_SLAVES'(1))) != '0             ? MULTI_SEL    :
                  (paddr & ADDRESS_WIDTH'(BW-1)) != '0                    ? UNALIGNED    :
                  32'(w_word) >= MEM_DEPTH_WORDS                          ? OUT_OF_RANGE :
                  !pwrite && pstrb != '0                                  ? READ_STRB    :
                  w_prot_err                                              ? PROT         : NONE;

    assign w_done = r_state == ACCESS && |pselx && penable && r_cnt == '0;

    for (genvar g = 0; g < NO_OF_SLAVES; g++) begin : g_bank
        assign w_we[g] = w_done && r_tx == WRITE && r_cause == NONE && r_idx == SW'(g);
        apb_slave_mem_bank #(.DEPTH(MEM_DEPTH_WORDS), .DW(DATA_WIDTH)) u_bank (
            .i_clk   (pclk),
            .i_we    (w_we[g]),
            .i_waddr (r_addr),
            .i_wdata (r_wdata),
            .i_strb  (r_strb),
            .i_raddr (w_raddr),
            .o_rdata (w_rd[g])
        );
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tx    <= READ;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_prot  <= '0;
            r_idx   <= '0;
            r_cause <= NONE;
            r_rdata <= '0;
        end else if (r_state == IDLE) begin
            if (|pselx && !penable) begin
                r_state <= ACCESS;
                r_cnt   <= cfg_wait_states[w_sel*WAIT_WIDTH +: WAIT_WIDTH];
                r_tx    <= pwrite ? WRITE : READ;
                r_addr  <= w_raddr;
                r_wdata <= pwdata;
                r_strb  <= pstrb;
                r_prot  <= pprot;
                r_idx   <= w_sel;
                r_cause <= w_cause;
                r_rdata <= w_rd[w_sel];
            end
        end else if (!(|pselx) || w_done) begin
            r_state <= IDLE;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign pready  = r_state == ACCESS && r_cnt == '0;
    assign w_resp  = pready && r_cause != NONE ? ERROR : NO_ERROR;
    assign pslverr = w_resp == ERROR;
    assign prdata  = pready && r_tx == READ && r_cause == NONE ? r_rdata : '0;
endmodule

// File: tb/tb_apb_multi_slave_memory.sv
// tb_apb_multi_slave_memory: directed APB transfers with a queued scoreboard checked by a separate monitor
module tb_apb_multi_slave_memory;
    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic [3:0]  pselx = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic [15:0] cfg_wait_states = {4'd5, 4'd3, 4'd0, 4'd1};
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          waits;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   waits = 0;

`ifdef APB_PPROT_CHECK_EN
    localparam logic        PROT_ERR = 1'b1;
    localparam logic [31:0] PROT_RD  = 32'h55AA55AA;
`else
    localparam logic        PROT_ERR = 1'b0;
    localparam logic [31:0] PROT_RD  = 32'h0000FFFF;
`endif

    apb_multi_slave_memory dut (
        .pclk            (pclk),
        .preset_n        (preset_n),
        .pselx           (pselx),
        .penable         (penable),
        .pwrite          (pwrite),
        .paddr           (paddr),
        .pwdata          (pwdata),
        .pstrb           (pstrb),
        .pprot           (pprot),
        .cfg_wait_states (cfg_wait_states),
        .prdata          (prdata),
        .pready          (pready),
        .pslverr         (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge pclk) begin : monitor
        exp_t e;
        if (preset_n && |pselx && penable) begin
            if (pready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_pready: got 1 expected no transfer");
                end else begin
                    e = q.pop_front();
                    check({e.name, "_prdata"}, prdata, e.data);
                    check({e.name, "_pslverr"}, 32'(pslverr), 32'(e.err));
                    if (e.waits >= 0) check({e.name, "_waits"}, waits, e.waits);
                end
                waits = 0;
            end else waits++;
        end else waits = 0;
    end

    task automatic apb_xfer(input logic [3:0] sel, input logic wr, input logic [11:0] addr,
                            input logic [31:0] wd, input logic [3:0] st, input logic [2:0] prot,
                            input logic ee, input logic [31:0] ed, input int ew, input string name);
        bit got;
        got = 1'b0;
        pselx = sel; penable = 1'b0; pwrite = wr; paddr = 32'(addr);
        pwdata = wd; pstrb = st; pprot = prot;
        q.push_back('{ed, ee, ew, name});
        @(posedge pclk) #1;
        penable = 1'b1;
        paddr = paddr ^ 32'h4;
        pwdata = ~wd;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge pclk);
            got = pready;
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got no pready expected pready within 40 cycles", name);
            void'(q.pop_back());
        end
        @(posedge pclk) #1;
        pselx = '0;
        penable = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge pclk);
        #1 preset_n = 1'b1;
        @(negedge pclk);
        check("rst_pready", 32'(pready), 0);
        check("rst_pslverr", 32'(pslverr), 0);
        check("rst_prdata", prdata, 0);
        @(posedge pclk) #1;

        apb_xfer(4'b0010, 1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b000, 0, 32'h0,        0, "s1_wr");
        apb_xfer(4'b0010, 0, 12'h010, 32'h0,        4'h0, 3'b000, 0, 32'hDEADBEEF, 0, "s1_rd");
        apb_xfer(4'b0100, 1, 12'h000, 32'hCAFEF00D, 4'hF, 3'b000, 0, 32'h0,        3, "s2_wr");
        apb_xfer(4'b0100, 0, 12'h000, 32'h0,        4'h0, 3'b000, 0, 32'hCAFEF00D, 3, "s2_rd");
        apb_xfer(4'b0001, 1, 12'h000, 32'h11223344, 4'hF, 3'b000, 0, 32'h0,        1, "s0_wr_full");
        apb_xfer(4'b0001, 1, 12'h000, 32'hAABBCCDD, 4'h5, 3'b000, 0, 32'h0,        1, "s0_wr_strb");
        apb_xfer(4'b0001, 0, 12'h000, 32'h0,        4'h0, 3'b000, 0, 32'h11BB33DD, 1, "s0_rd_merge");
        apb_xfer(4'b0001, 1, 12'h002, 32'hFFFFFFFF, 4'hF, 3'b000, 1, 32'h0,        1, "unaligned_wr");
        apb_xfer(4'b0001, 0, 12'h402, 32'h0,        4'h0, 3'b000, 1, 32'h0,        1, "unaligned_rd");
        apb_xfer(4'b0001, 1, 12'h400, 32'hFFFFFFFF, 4'hF, 3'b000, 1, 32'h0,        1, "oor_wr");
        apb_xfer(4'b0001, 0, 12'h000, 32'h0,        4'h0, 3'b000, 0, 32'h11BB33DD, 1, "s0_rd_intact");
        apb_xfer(4'b0011, 1, 12'h010, 32'hFFFFFFFF, 4'hF, 3'b000, 1, 32'h0,       -1, "multisel_wr");
        apb_xfer(4'b0010, 0, 12'h010, 32'h0,        4'h1, 3'b000, 1, 32'h0,        0, "rd_strb");
        apb_xfer(4'b0010, 1, 12'h010, 32'h0,        4'h0, 3'b000, 0, 32'h0,        0, "wr_strb0");
        apb_xfer(4'b0010, 0, 12'h010, 32'h0,        4'h0, 3'b000, 0, 32'hDEADBEEF, 0, "s1_rd_intact");
        apb_xfer(4'b1000, 1, 12'h020, 32'h12345678, 4'hF, 3'b000, 0, 32'h0,        5, "s3_wr");

        pselx = 4'b1000; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hFFFFFFFF; pstrb = 4'hF; penable = 1'b0;
        @(posedge pclk) #1;
        penable = 1'b1;
        @(posedge pclk) #1;
        preset_n = 1'b0;
        @(posedge pclk) #1;
        preset_n = 1'b1;
        pselx = '0;
        penable = 1'b0;
        @(negedge pclk);
        check("abort_pready", 32'(pready), 0);
        check("abort_pslverr", 32'(pslverr), 0);
        check("abort_prdata", prdata, 0);
        @(posedge pclk) #1;
        apb_xfer(4'b1000, 0, 12'h020, 32'h0,        4'h0, 3'b000, 0, 32'h12345678, 5, "s3_rd_after_rst");

        apb_xfer(4'b0001, 1, 12'h004, 32'h55AA55AA, 4'hF, 3'b000, 0,        32'h0,   1, "s0_prot_ok");
        apb_xfer(4'b0001, 1, 12'h004, 32'h0000FFFF, 4'hF, 3'b010, PROT_ERR, 32'h0,   1, "s0_prot_ns");
        apb_xfer(4'b0001, 0, 12'h004, 32'h0,        4'h0, 3'b000, 0,        PROT_RD, 1, "s0_prot_rd");

        repeat (3) @(posedge pclk);
        if (q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL leftover_expectations: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
